// File: rtl/rs_multi_pkg.sv
// Shared constants for the reservation station: opcode encodings, boolean
// levels and the reserved "no producer" ROB tag.
package rs_multi_pkg;

  typedef enum logic [5:0] {
    OP_NOP = 6'd0,
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_AND = 6'd3,
    OP_OR  = 6'd4,
    OP_XOR = 6'd5
  } op_e;

  localparam op_e  NOP          = OP_NOP;
  localparam logic TRUE         = 1'b1;
  localparam logic FALSE        = 1'b0;
  localparam int   ZERO_TAG_ROB = 0;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: an entry is granted when it is ready and no other
// ready entry is older than it according to the age matrix.
module rs_age_select #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH*DEPTH-1:0] i_age,
  input  logic [DEPTH-1:0]       i_ready,
  output logic [DEPTH-1:0]       o_grant
);

  // i_age[j*DEPTH+i] set means entry j was dispatched before entry i.
  // NOTE: o_grant gets its default before the loops so every path assigns it and no latch is inferred.
  always_comb begin
    o_grant = i_ready;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && i_ready[j] && i_age[j*DEPTH+i]) begin
          o_grant[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rs_multi.sv
// Reservation station with CDB wakeup, same-cycle dispatch bypass and
// oldest-ready issue into a single registered issue slot.
module rs_multi
  import rs_multi_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 3,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      in_flush,
  input  logic                      in_dispatch_valid,
  output logic                      out_dispatch_ready,
  input  logic [TAG_W-1:0]          in_dispatch_rob_tag,
  input  logic [TAG_W-1:0]          in_dispatch_tag1,
  input  logic [TAG_W-1:0]          in_dispatch_tag2,
  input  logic [OP_W-1:0]           in_dispatch_op,
  input  logic [DATA_W-1:0]         in_dispatch_value1,
  input  logic [DATA_W-1:0]         in_dispatch_value2,
  input  logic [DATA_W-1:0]         in_dispatch_imm,
  input  logic [DATA_W-1:0]         in_dispatch_pc,
  input  logic [NUM_CDB-1:0]        in_cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  in_cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] in_cdb_value,
  output logic                      out_issue_valid,
  input  logic                      in_issue_ready,
  output logic [OP_W-1:0]           out_issue_op,
  output logic [DATA_W-1:0]         out_issue_value1,
  output logic [DATA_W-1:0]         out_issue_value2,
  output logic [DATA_W-1:0]         out_issue_imm,
  output logic [DATA_W-1:0]         out_issue_pc,
  output logic [TAG_W-1:0]          out_issue_rob_tag,
  output logic [$clog2(DEPTH):0]    out_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Entry state
  logic [DEPTH-1:0]             r_busy;
  logic [DEPTH-1:0][DEPTH-1:0]  r_age;
  logic [OP_W-1:0]              r_op   [DEPTH];
  logic [DATA_W-1:0]            r_v1   [DEPTH];
  logic [DATA_W-1:0]            r_v2   [DEPTH];
  logic [DATA_W-1:0]            r_imm  [DEPTH];
  logic [DATA_W-1:0]            r_pc   [DEPTH];
  logic [TAG_W-1:0]             r_t1   [DEPTH];
  logic [TAG_W-1:0]             r_t2   [DEPTH];
  logic [TAG_W-1:0]             r_rob  [DEPTH];
  logic [CNT_W-1:0]             r_count;

  // Issue slot
  logic                         r_issue_valid;
  logic [OP_W-1:0]              r_issue_op;
  logic [DATA_W-1:0]            r_issue_v1;
  logic [DATA_W-1:0]            r_issue_v2;
  logic [DATA_W-1:0]            r_issue_imm;
  logic [DATA_W-1:0]            r_issue_pc;
  logic [TAG_W-1:0]             r_issue_rob;

  logic                         w_active;
  logic                         w_dispatch;
  logic                         w_issue_slot;
  logic                         w_issue;
  logic                         w_any;
  logic [DEPTH-1:0]             w_ready;
  logic [DEPTH-1:0]             w_grant;
  logic [DEPTH-1:0]             w_free_vec;
  logic [IDX_W-1:0]             w_free_idx;
  logic [IDX_W-1:0]             w_grant_idx;
  logic [DEPTH*DEPTH-1:0]       w_age_flat;
  logic [DEPTH-1:0]             w_busy_next;
  logic [DEPTH-1:0][DEPTH-1:0]  w_age_next;
  logic [CNT_W-1:0]             w_count_next;
  logic [DATA_W:0]              w_disp1;
  logic [DATA_W:0]              w_disp2;
  logic [DATA_W:0]              w_wake1 [DEPTH];
  logic [DATA_W:0]              w_wake2 [DEPTH];

  // Returns {hit, value}; scanning high to low lets the lowest channel win.
  function automatic logic [DATA_W:0] cdb_match(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        vld,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] vals
  );
    logic [DATA_W:0] res;
    res = '0;
    if (tag != TAG_W'(ZERO_TAG_ROB)) begin
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (vld[k] && tags[k*TAG_W +: TAG_W] == tag) begin
          res = {1'b1, vals[k*DATA_W +: DATA_W]};
        end
      end
    end
    return res;
  endfunction

  assign w_active           = rdy && !in_flush;
  assign out_dispatch_ready = (r_count < CNT_W'(DEPTH));
  assign w_dispatch         = w_active && in_dispatch_valid && out_dispatch_ready &&
                              (in_dispatch_rob_tag != TAG_W'(ZERO_TAG_ROB));
  assign w_issue_slot       = !r_issue_valid || in_issue_ready;
  assign w_any              = |w_grant;
  assign w_issue            = w_active && w_any && w_issue_slot;
  assign w_free_vec         = w_issue ? w_grant : '0;
  assign w_age_flat         = r_age;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = r_busy[i] && (r_t1[i] == '0) && (r_t2[i] == '0);
      w_wake1[i] = cdb_match(r_t1[i], in_cdb_valid, in_cdb_tag, in_cdb_value);
      w_wake2[i] = cdb_match(r_t2[i], in_cdb_valid, in_cdb_tag, in_cdb_value);
    end
    w_disp1 = cdb_match(in_dispatch_tag1, in_cdb_valid, in_cdb_tag, in_cdb_value);
    w_disp2 = cdb_match(in_dispatch_tag2, in_cdb_valid, in_cdb_tag, in_cdb_value);
  end

  always_comb begin
    w_free_idx  = '0;
    w_grant_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) w_grant_idx = IDX_W'(i);
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age_select (
    .i_age   (w_age_flat),
    .i_ready (w_ready),
    .o_grant (w_grant)
  );

  // A new entry is younger than every entry still resident after this edge.
  always_comb begin
    w_busy_next  = r_busy & ~w_free_vec;
    w_age_next   = r_age;
    w_count_next = r_count + CNT_W'(w_dispatch) - CNT_W'(w_issue);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_free_vec[i]) begin
        w_age_next[i] = '0;
        for (int j = 0; j < DEPTH; j++) w_age_next[j][i] = 1'b0;
      end
    end
    if (w_dispatch) begin
      w_busy_next[w_free_idx] = 1'b1;
      w_age_next[w_free_idx]  = '0;
      for (int j = 0; j < DEPTH; j++) begin
        w_age_next[j][w_free_idx] = r_busy[j] & ~w_free_vec[j];
      end
    end
  end

  // NOTE: entry payload has no reset; it is only observed while busy, which is reset.
  always_ff @(posedge clk) begin
    if (w_active) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_dispatch && w_free_idx == IDX_W'(i)) begin
          r_op[i]  <= in_dispatch_op;
          r_imm[i] <= in_dispatch_imm;
          r_pc[i]  <= in_dispatch_pc;
          r_rob[i] <= in_dispatch_rob_tag;
          r_t1[i]  <= w_disp1[DATA_W] ? '0 : in_dispatch_tag1;
          r_v1[i]  <= w_disp1[DATA_W] ? w_disp1[DATA_W-1:0] : in_dispatch_value1;
          r_t2[i]  <= w_disp2[DATA_W] ? '0 : in_dispatch_tag2;
          r_v2[i]  <= w_disp2[DATA_W] ? w_disp2[DATA_W-1:0] : in_dispatch_value2;
        end else if (r_busy[i]) begin
          if (w_wake1[i][DATA_W]) begin
            r_t1[i] <= '0;
            r_v1[i] <= w_wake1[i][DATA_W-1:0];
          end
          if (w_wake2[i][DATA_W]) begin
            r_t2[i] <= '0;
            r_v2[i] <= w_wake2[i][DATA_W-1:0];
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy        <= '0;
      r_age         <= '0;
      r_count       <= '0;
      r_issue_valid <= FALSE;
      r_issue_op    <= OP_W'(NOP);
      r_issue_v1    <= '0;
      r_issue_v2    <= '0;
      r_issue_imm   <= '0;
      r_issue_pc    <= '0;
      r_issue_rob   <= TAG_W'(ZERO_TAG_ROB);
    end else if (rdy) begin
      if (in_flush) begin
        r_busy        <= '0;
        r_age         <= '0;
        r_count       <= '0;
        r_issue_valid <= FALSE;
      end else begin
        r_busy  <= w_busy_next;
        r_age   <= w_age_next;
        r_count <= w_count_next;
        if (w_issue_slot) begin
          r_issue_valid <= w_any;
          if (w_any) begin
            r_issue_op  <= r_op[w_grant_idx];
            r_issue_v1  <= r_v1[w_grant_idx];
            r_issue_v2  <= r_v2[w_grant_idx];
            r_issue_imm <= r_imm[w_grant_idx];
            r_issue_pc  <= r_pc[w_grant_idx];
            r_issue_rob <= r_rob[w_grant_idx];
          end
        end
      end
    end
  end

  assign out_issue_valid   = r_issue_valid;
  assign out_issue_op      = r_issue_op;
  assign out_issue_value1  = r_issue_v1;
  assign out_issue_value2  = r_issue_v2;
  assign out_issue_imm     = r_issue_imm;
  assign out_issue_pc      = r_issue_pc;
  assign out_issue_rob_tag = r_issue_rob;
  assign out_count         = r_count;

endmodule

// File: tb/tb_rs_multi.sv
// Scoreboard bench for rs_multi: stimulus pushes expected issues, a negedge
// monitor pops and compares on every issue handshake.
module tb_rs_multi;
  import rs_multi_pkg::*;

  localparam int DEPTH = 16, NUM_CDB = 3, TAG_W = 4, DATA_W = 32, OP_W = 6;

  logic                      clk = 1'b0;
  logic                      rst, rdy, in_flush, in_dispatch_valid, out_dispatch_ready;
  logic [TAG_W-1:0]          in_dispatch_rob_tag, in_dispatch_tag1, in_dispatch_tag2;
  logic [OP_W-1:0]           in_dispatch_op;
  logic [DATA_W-1:0]         in_dispatch_value1, in_dispatch_value2, in_dispatch_imm, in_dispatch_pc;
  logic [NUM_CDB-1:0]        in_cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  in_cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] in_cdb_value;
  logic                      out_issue_valid, in_issue_ready;
  logic [OP_W-1:0]           out_issue_op;
  logic [DATA_W-1:0]         out_issue_value1, out_issue_value2, out_issue_imm, out_issue_pc;
  logic [TAG_W-1:0]          out_issue_rob_tag;
  logic [$clog2(DEPTH):0]    out_count;

  rs_multi #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_flush(in_flush),
    .in_dispatch_valid(in_dispatch_valid), .out_dispatch_ready(out_dispatch_ready),
    .in_dispatch_rob_tag(in_dispatch_rob_tag), .in_dispatch_tag1(in_dispatch_tag1),
    .in_dispatch_tag2(in_dispatch_tag2), .in_dispatch_op(in_dispatch_op),
    .in_dispatch_value1(in_dispatch_value1), .in_dispatch_value2(in_dispatch_value2),
    .in_dispatch_imm(in_dispatch_imm), .in_dispatch_pc(in_dispatch_pc),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .out_issue_valid(out_issue_valid), .in_issue_ready(in_issue_ready),
    .out_issue_op(out_issue_op), .out_issue_value1(out_issue_value1),
    .out_issue_value2(out_issue_value2), .out_issue_imm(out_issue_imm),
    .out_issue_pc(out_issue_pc), .out_issue_rob_tag(out_issue_rob_tag),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0]  rob;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1, v2, imm, pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] imm_of(input logic [TAG_W-1:0] rob);
    return 32'h100 + DATA_W'(rob);
  endfunction

  function automatic logic [DATA_W-1:0] pc_of(input logic [TAG_W-1:0] rob);
    return 32'h4000 + DATA_W'(rob) * 4;
  endfunction

  task automatic push_exp(input logic [TAG_W-1:0] rob, input logic [OP_W-1:0] op,
                          input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
    exp_t e;
    e.rob = rob; e.op = op; e.v1 = v1; e.v2 = v2; e.imm = imm_of(rob); e.pc = pc_of(rob);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && rdy && !in_flush && out_issue_valid && in_issue_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_issue: got rob_tag 0x%0h with nothing expected", out_issue_rob_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_rob_tag", 64'(out_issue_rob_tag), 64'(mon_e.rob));
        check("issue_op",      64'(out_issue_op),      64'(mon_e.op));
        check("issue_value1",  64'(out_issue_value1),  64'(mon_e.v1));
        check("issue_value2",  64'(out_issue_value2),  64'(mon_e.v2));
        check("issue_imm",     64'(out_issue_imm),     64'(mon_e.imm));
        check("issue_pc",      64'(out_issue_pc),      64'(mon_e.pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dispatch(input logic [TAG_W-1:0] rob, input logic [OP_W-1:0] op,
                                input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                                input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
    in_dispatch_rob_tag = rob; in_dispatch_op = op;
    in_dispatch_tag1 = t1; in_dispatch_tag2 = t2;
    in_dispatch_value1 = v1; in_dispatch_value2 = v2;
    in_dispatch_imm = imm_of(rob); in_dispatch_pc = pc_of(rob);
  endtask

  task automatic dispatch(input logic [TAG_W-1:0] rob, input logic [OP_W-1:0] op,
                          input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                          input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
    drive_dispatch(rob, op, t1, t2, v1, v2);
    in_dispatch_valid = 1'b1;
    tick();
    in_dispatch_valid = 1'b0;
  endtask

  task automatic cdb_set(input int ch, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
    in_cdb_valid[ch]                 = 1'b1;
    in_cdb_tag[ch*TAG_W +: TAG_W]    = tag;
    in_cdb_value[ch*DATA_W +: DATA_W] = val;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; in_flush = 1'b0; in_issue_ready = 1'b1;
    in_dispatch_valid = 1'b0; in_cdb_valid = '0; in_cdb_tag = '0; in_cdb_value = '0;
    drive_dispatch('0, OP_NOP, '0, '0, '0, '0);
    #3;
    check("rst_count",        64'(out_count),          64'd0);
    check("rst_issue_valid",  64'(out_issue_valid),    64'd0);
    check("rst_issue_op",     64'(out_issue_op),       64'(OP_NOP));
    check("rst_issue_rob",    64'(out_issue_rob_tag),  64'd0);
    check("rst_disp_ready",   64'(out_dispatch_ready), 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Ready dispatch: valid rises two edges after dispatch
    push_exp(4'd5, OP_ADD, 32'd3, 32'd4);
    dispatch(4'd5, OP_ADD, 4'd0, 4'd0, 32'd3, 32'd4);
    check("t1_valid_after_1_edge", 64'(out_issue_valid), 64'd0);
    check("t1_count",              64'(out_count),       64'd1);
    tick();
    check("t1_valid_after_2_edges", 64'(out_issue_valid),   64'd1);
    check("t1_rob_tag",             64'(out_issue_rob_tag), 64'd5);
    drain();

    // Rob tag 0 and rdy-low dispatches are dropped
    dispatch(4'd0, OP_ADD, 4'd0, 4'd0, 32'd1, 32'd1);
    check("rob0_dropped_count", 64'(out_count), 64'd0);
    rdy = 1'b0;
    dispatch(4'd4, OP_ADD, 4'd0, 4'd0, 32'd1, 32'd1);
    rdy = 1'b1;
    check("rdy_low_count", 64'(out_count), 64'd0);
    tick();
    check("dropped_no_issue", 64'(out_issue_valid), 64'd0);

    // Wakeup via CDB channel 1
    push_exp(4'd6, OP_ADD, 32'hAB, 32'd2);
    dispatch(4'd6, OP_ADD, 4'd7, 4'd0, 32'd0, 32'd2);
    tick(); tick();
    check("t2_waiting", 64'(out_issue_valid), 64'd0);
    cdb_set(1, 4'd7, 32'hAB);
    tick();
    in_cdb_valid = '0;
    check("t2_not_yet", 64'(out_issue_valid), 64'd0);
    tick();
    check("t2_valid",  64'(out_issue_valid),  64'd1);
    check("t2_value1", 64'(out_issue_value1), 64'hAB);
    drain();

    // Same-cycle bypass on CDB channel 0
    push_exp(4'd8, OP_SUB, 32'h55, 32'h10);
    cdb_set(0, 4'd9, 32'h10);
    dispatch(4'd8, OP_SUB, 4'd0, 4'd9, 32'h55, 32'd0);
    in_cdb_valid = '0;
    tick();
    check("t3_valid",  64'(out_issue_valid),  64'd1);
    check("t3_value2", 64'(out_issue_value2), 64'h10);
    drain();

    // A waits on tag 3, B ready: B takes the slot, A follows after release
    in_issue_ready = 1'b0;
    dispatch(4'd10, OP_ADD, 4'd3, 4'd0, 32'd0, 32'd1);
    dispatch(4'd11, OP_ADD, 4'd0, 4'd0, 32'd5, 32'd6);
    cdb_set(2, 4'd3, 32'h33);
    tick();
    in_cdb_valid = '0;
    tick();
    check("t4_holds_b",  64'(out_issue_rob_tag), 64'd11);
    check("t4_valid",    64'(out_issue_valid),   64'd1);
    check("t4_count",    64'(out_count),         64'd1);
    push_exp(4'd11, OP_ADD, 32'd5, 32'd6);
    push_exp(4'd10, OP_ADD, 32'h33, 32'd1);
    in_issue_ready = 1'b1;
    drain();

    // Older entry at higher index beats younger entry at index 0
    in_issue_ready = 1'b0;
    dispatch(4'd13, OP_ADD, 4'd0, 4'd0, 32'd1, 32'd1);
    dispatch(4'd14, OP_ADD, 4'd2, 4'd0, 32'd0, 32'h44);
    check("simul_issue_dispatch_count", 64'(out_count), 64'd1);
    dispatch(4'd15, OP_ADD, 4'd0, 4'd2, 32'h66, 32'd0);
    cdb_set(0, 4'd2, 32'h22);
    tick();
    in_cdb_valid = '0;
    tick();
    check("t4b_holds_p", 64'(out_issue_rob_tag), 64'd13);
    check("t4b_count",   64'(out_count),         64'd2);
    push_exp(4'd13, OP_ADD, 32'd1, 32'd1);
    push_exp(4'd14, OP_ADD, 32'h22, 32'h44);
    push_exp(4'd15, OP_ADD, 32'h66, 32'h22);
    in_issue_ready = 1'b1;
    drain();

    // Fill all entries behind a stalled issue slot
    in_issue_ready = 1'b0;
    dispatch(4'd1, OP_ADD, 4'd0, 4'd0, 32'h77, 32'h88);
    for (int k = 0; k < DEPTH; k++) begin
      dispatch(4'((k % 14) + 1), OP_ADD, 4'd15, 4'd0, 32'd0, 32'(k));
    end
    check("full_count",       64'(out_count),          64'd16);
    check("full_disp_ready",  64'(out_dispatch_ready), 64'd0);
    dispatch(4'd3, OP_ADD, 4'd0, 4'd0, 32'd9, 32'd9);
    check("full_drop_count",  64'(out_count),          64'd16);
    tick(); tick(); tick();
    check("stall_valid",  64'(out_issue_valid),   64'd1);
    check("stall_rob",    64'(out_issue_rob_tag), 64'd1);
    check("stall_value1", 64'(out_issue_value1),  64'h77);
    check("stall_value2", 64'(out_issue_value2),  64'h88);

    // Flush with a same-cycle dispatch
    drive_dispatch(4'd2, OP_ADD, 4'd0, 4'd0, 32'd1, 32'd1);
    in_dispatch_valid = 1'b1; in_flush = 1'b1;
    tick();
    in_dispatch_valid = 1'b0; in_flush = 1'b0;
    check("flush_full_count",  64'(out_count),          64'd0);
    check("flush_full_valid",  64'(out_issue_valid),    64'd0);
    check("flush_disp_ready",  64'(out_dispatch_ready), 64'd1);

    // Five busy entries plus a pending issue, then flush
    dispatch(4'd12, OP_ADD, 4'd0, 4'd0, 32'd1, 32'd2);
    for (int k = 0; k < 5; k++) begin
      dispatch(4'(k + 1), OP_ADD, 4'd14, 4'd0, 32'd0, 32'd0);
    end
    check("pre_flush_count", 64'(out_count),       64'd5);
    check("pre_flush_valid", 64'(out_issue_valid), 64'd1);
    drive_dispatch(4'd6, OP_ADD, 4'd0, 4'd0, 32'd1, 32'd1);
    in_dispatch_valid = 1'b1; in_flush = 1'b1;
    tick();
    in_dispatch_valid = 1'b0; in_flush = 1'b0;
    check("flush_count", 64'(out_count),       64'd0);
    check("flush_valid", 64'(out_issue_valid), 64'd0);
    tick();
    check("flush_dispatch_not_stored", 64'(out_count),       64'd0);
    check("flush_no_issue",            64'(out_issue_valid), 64'd0);

    // Asynchronous reset mid-operation
    dispatch(4'd9, OP_XOR, 4'd0, 4'd0, 32'd3, 32'd3);
    dispatch(4'd8, OP_ADD, 4'd11, 4'd0, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_count", 64'(out_count),         64'd0);
    check("midrst_valid", 64'(out_issue_valid),   64'd0);
    check("midrst_op",    64'(out_issue_op),      64'(OP_NOP));
    check("midrst_rob",   64'(out_issue_rob_tag), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Normal operation resumes
    in_issue_ready = 1'b1;
    push_exp(4'd7, OP_AND, 32'h99, 32'h1);
    dispatch(4'd7, OP_AND, 4'd0, 4'd0, 32'h99, 32'h1);
    drain();
    check("final_count", 64'(out_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
